// File: rtl/complex_op_stim_gen.sv
// complex_op_stim_gen
//   Traffic generator and result checker for the complex-number multiplier.
//   Issues txn_num operand transactions per run over a valid/ready handshake,
//   then accepts each result with a programmable delay on res_ready. Counts
//   completed result handshakes and, optionally, mismatching results.
//
//   Optional feature macro: COMPLEX_STIM_CHECK_EN
//     defined   : expected-value registers, comparator, err_cnt and err present
//     undefined : checker omitted, err_cnt/err tied to 0, res_re/res_im unused
//
// Ports
//   clk                  rising-edge clock
//   sw_rst               synchronous reset, active high
//   start                one-cycle run start, honoured in IDLE and DONE
//   mode                 0 sweep, 1 random, 2 corner, 3 alternate
//   txn_num              transactions per run, sampled on start
//   op_ready             multiplier accepts operands
//   res_val              multiplier result valid
//   res_re, res_im       multiplier result (two's complement)
//   op_val               operands valid
//   op_1_re..op_2_im     operands (unsigned)
//   res_ready            result accepted
//   busy, done           run status
//   txn_cnt              completed result handshakes this run
//   err_cnt, err         saturating mismatch count, sticky mismatch flag
module complex_op_stim_gen #(
    parameter int          DATA_WIDTH    = 8,
    parameter int          RES_WIDTH     = 2*DATA_WIDTH+2,
    parameter int          TXN_CNT_WIDTH = 10,
    parameter int          GAP_CYCLES    = 2,
    parameter int          RDY_DELAY     = 20,
    parameter logic [31:0] LFSR_SEED     = 32'hACE1_2468
) (
    input  logic                     clk,
    input  logic                     sw_rst,
    input  logic                     start,
    input  logic [1:0]               mode,
    input  logic [TXN_CNT_WIDTH-1:0] txn_num,
    input  logic                     op_ready,
    input  logic                     res_val,
    input  logic [RES_WIDTH-1:0]     res_re,
    input  logic [RES_WIDTH-1:0]     res_im,
    output logic                     op_val,
    output logic [DATA_WIDTH-1:0]    op_1_re,
    output logic [DATA_WIDTH-1:0]    op_1_im,
    output logic [DATA_WIDTH-1:0]    op_2_re,
    output logic [DATA_WIDTH-1:0]    op_2_im,
    output logic                     res_ready,
    output logic                     busy,
    output logic                     done,
    output logic [TXN_CNT_WIDTH-1:0] txn_cnt,
    output logic [TXN_CNT_WIDTH-1:0] err_cnt,
    output logic                     err
);
    localparam logic [31:0] LFSR_INIT = (LFSR_SEED == 32'd0) ? 32'd1 : LFSR_SEED;
    localparam logic [7:0]  GAP_LAST  = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
    localparam logic [7:0]  DLY_LAST  = (RDY_DELAY > 0) ? 8'(RDY_DELAY - 1) : 8'd0;

    typedef enum logic [2:0] {
        S_IDLE, S_GAP, S_LOAD, S_DRIVE, S_WAIT_RES, S_ACK, S_DONE
    } state_t;

    // With no idle gap the run goes straight to the operand load.
    localparam state_t S_FIRST = (GAP_CYCLES == 0) ? S_LOAD : S_GAP;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] a;  // op_1_re
        logic [DATA_WIDTH-1:0] b;  // op_1_im
        logic [DATA_WIDTH-1:0] c;  // op_2_re
        logic [DATA_WIDTH-1:0] d;  // op_2_im
    } ops_t;

    state_t                   state, state_n;
    ops_t                     ops, ops_n;
    logic [31:0]              lfsr, lfsr_n, s1, s2, s3, s4, k;
    logic [TXN_CNT_WIDTH-1:0] txn_req, txn_cnt_inc;
    logic [7:0]               gap_cnt, dly_cnt;
    logic                     res_seen, dly_hit, start_acc, use_rand, res_hs;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    assign op_1_re   = ops.a;
    assign op_1_im   = ops.b;
    assign op_2_re   = ops.c;
    assign op_2_im   = ops.d;
    assign op_val    = (state == S_DRIVE);
    assign res_ready = (state == S_ACK);
    assign done      = (state == S_DONE);
    assign busy      = (state != S_IDLE) && (state != S_DONE);

    assign txn_cnt_inc = txn_cnt + TXN_CNT_WIDTH'(1);
    assign res_hs      = (state == S_ACK) && res_val;
    // Before the first res_val the counter is idle; with zero delay the
    // first sighting itself moves the FSM to ACK.
    assign dly_hit     = res_seen ? (dly_cnt == DLY_LAST) : (res_val && (RDY_DELAY == 0));

    // Operand generation for transaction index k = txn_cnt (one in flight).
    always_comb begin
        k        = 32'(txn_cnt);
        s1       = lfsr_step(lfsr);
        s2       = lfsr_step(s1);
        s3       = lfsr_step(s2);
        s4       = lfsr_step(s3);
        lfsr_n   = s4;
        use_rand = (mode == 2'd1) || ((mode == 2'd3) && !txn_cnt[0]);
        ops_n    = '1;
        if (use_rand) begin
            ops_n.a = s1[DATA_WIDTH-1:0];
            ops_n.b = s2[DATA_WIDTH-1:0];
            ops_n.c = s3[DATA_WIDTH-1:0];
            ops_n.d = s4[DATA_WIDTH-1:0];
        end else if (mode == 2'd0) begin
            ops_n.a = DATA_WIDTH'(k);
            ops_n.b = DATA_WIDTH'(k + 32'd1);
            ops_n.c = DATA_WIDTH'(k + 32'd2);
            ops_n.d = DATA_WIDTH'(k + 32'd3);
        end
    end

    always_comb begin
        state_n   = state;
        start_acc = 1'b0;
        unique case (state)
            S_IDLE, S_DONE: if (start) begin
                start_acc = 1'b1;
                state_n   = (txn_num == '0) ? S_DONE : S_FIRST;
            end
            S_GAP:      if (gap_cnt == GAP_LAST) state_n = S_LOAD;
            S_LOAD:     state_n = S_DRIVE;
            S_DRIVE:    if (op_ready) state_n = S_WAIT_RES;
            S_WAIT_RES: if (dly_hit) state_n = S_ACK;
            S_ACK:      if (res_val) state_n = (txn_cnt_inc == txn_req) ? S_DONE : S_FIRST;
            default:    state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sw_rst) state <= S_IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (sw_rst) begin
            ops      <= '0;
            lfsr     <= LFSR_INIT;
            txn_cnt  <= '0;
            txn_req  <= '0;
            gap_cnt  <= '0;
            dly_cnt  <= '0;
            res_seen <= 1'b0;
        end else begin
            if (start_acc) begin
                txn_cnt <= '0;
                txn_req <= txn_num;
            end
            if (res_hs) txn_cnt <= txn_cnt_inc;

            gap_cnt <= (state == S_GAP) ? gap_cnt + 8'd1 : 8'd0;

            if (state == S_LOAD) begin
                ops <= ops_n;
                if (use_rand) lfsr <= lfsr_n;
            end

            if (state != S_WAIT_RES) begin
                res_seen <= 1'b0;
                dly_cnt  <= '0;
            end else if (!res_seen) begin
                res_seen <= res_val;
            end else begin
                dly_cnt <= dly_cnt + 8'd1;
            end
        end
    end

`ifdef COMPLEX_STIM_CHECK_EN
    localparam int PW = 2*DATA_WIDTH + 1;

    logic [PW-1:0]        p_ac, p_bd, p_ad, p_bc, re_full;
    logic [RES_WIDTH-1:0] exp_re, exp_im, exp_re_n, exp_im_n;

    // Expected result of the operands about to be loaded. The real part is
    // formed modulo 2^PW, which is exact two's complement for a*c - b*d.
    always_comb begin
        p_ac     = PW'(ops_n.a) * PW'(ops_n.c);
        p_bd     = PW'(ops_n.b) * PW'(ops_n.d);
        p_ad     = PW'(ops_n.a) * PW'(ops_n.d);
        p_bc     = PW'(ops_n.b) * PW'(ops_n.c);
        re_full  = p_ac - p_bd;
        exp_re_n = RES_WIDTH'($signed(re_full));
        exp_im_n = RES_WIDTH'(p_ad + p_bc);
    end

    always_ff @(posedge clk) begin
        if (sw_rst) begin
            exp_re  <= '0;
            exp_im  <= '0;
            err_cnt <= '0;
            err     <= 1'b0;
        end else begin
            if (state == S_LOAD) begin
                exp_re <= exp_re_n;
                exp_im <= exp_im_n;
            end
            if (start_acc) begin
                err_cnt <= '0;
                err     <= 1'b0;
            end else if (res_hs && ((res_re != exp_re) || (res_im != exp_im))) begin
                err <= 1'b1;
                if (err_cnt != '1) err_cnt <= err_cnt + TXN_CNT_WIDTH'(1);
            end
        end
    end
`else
    logic unused_res;
    assign unused_res = ^{res_re, res_im};
    assign err_cnt    = '0;
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_complex_op_stim_gen.sv
// tb_complex_op_stim_gen
//   Directed bench for complex_op_stim_gen with default parameters. The bench
//   plays the multiplier: it accepts operands, returns a product computed
//   here, and measures handshake timing.
module tb_complex_op_stim_gen;
    localparam int          DW   = 8;
    localparam int          RW   = 2*DW+2;
    localparam int          TW   = 10;
    localparam int          GAP  = 2;
    localparam int          DLY  = 20;
    localparam logic [31:0] SEED = 32'hACE1_2468;
`ifdef COMPLEX_STIM_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          sw_rst, start, op_ready, res_val;
    logic [1:0]    mode;
    logic [TW-1:0] txn_num;
    logic [RW-1:0] res_re, res_im;
    logic          op_val, res_ready, busy, done, err;
    logic [DW-1:0] op_1_re, op_1_im, op_2_re, op_2_im;
    logic [TW-1:0] txn_cnt, err_cnt;

    int            checks = 0;
    int            errors = 0;
    logic [31:0]   lfsr_m = SEED;

    always #5 clk = ~clk;

    complex_op_stim_gen #(
        .DATA_WIDTH(DW), .RES_WIDTH(RW), .TXN_CNT_WIDTH(TW),
        .GAP_CYCLES(GAP), .RDY_DELAY(DLY), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .sw_rst(sw_rst), .start(start), .mode(mode), .txn_num(txn_num),
        .op_ready(op_ready), .res_val(res_val), .res_re(res_re), .res_im(res_im),
        .op_val(op_val), .op_1_re(op_1_re), .op_1_im(op_1_im), .op_2_re(op_2_re),
        .op_2_im(op_2_im), .res_ready(res_ready), .busy(busy), .done(done),
        .txn_cnt(txn_cnt), .err_cnt(err_cnt), .err(err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tmo(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: timeout waiting for DUT", tag);
    endtask

    function automatic logic [31:0] lstep(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ctl"}, 64'({op_val, res_ready, busy, done}), 64'd0);
        chk({tag, "_cnt"}, 64'({txn_cnt, err_cnt, err}), 64'd0);
        chk({tag, "_ops"}, 64'({op_1_re, op_1_im, op_2_re, op_2_im}), 64'd0);
    endtask

    task automatic start_run(input logic [1:0] m, input logic [TW-1:0] n);
        @(negedge clk);
        mode = m; txn_num = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'(n != '0));
        chk("done_after_start", 64'(done), 64'(n == '0));
    endtask

    task automatic wait_op(output int w);
        w = 0;
        while (!op_val && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!op_val) tmo("op_val");
    endtask

    task automatic chk_ops(input string tag, input logic [DW-1:0] a, b, c, d);
        chk(tag, 64'({op_1_re, op_1_im, op_2_re, op_2_im}), 64'({a, b, c, d}));
    endtask

    // One-cycle op_ready; afterwards op_val must be low (now in WAIT_RES).
    task automatic op_hs();
        op_ready = 1'b1;
        @(negedge clk);
        op_ready = 1'b0;
        chk("op_val_after_hs", 64'(op_val), 64'd0);
    endtask

    // Present a result from the first WAIT_RES negedge and check the
    // res_ready delay: res_val sampled on the next edge, ACK DLY edges later.
    task automatic res_phase(input int re, input int im);
        int w;
        res_re = RW'(re); res_im = RW'(im); res_val = 1'b1;
        w = 0;
        while (!res_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!res_ready) tmo("res_ready");
        else chk("res_ready_delay", 64'(w), 64'(DLY + 1));
        chk("busy_in_ack", 64'({busy, done}), 64'b10);
        @(negedge clk);
        res_val = 1'b0;
        chk("res_ready_after_hs", 64'(res_ready), 64'd0);
    endtask

    task automatic do_txn(input string tag, input logic [DW-1:0] a, b, c, d,
                          input bit inject, input bit first);
        int w;
        int re, im;
        wait_op(w);
        chk_ops(tag, a, b, c, d);
        if (first) chk("first_op_latency", 64'(w + 1), 64'(GAP + 2));
        op_hs();
        re = int'(a) * int'(c) - int'(b) * int'(d);
        im = int'(a) * int'(d) + int'(b) * int'(c) + (inject ? 1 : 0);
        res_phase(re, im);
    endtask

    task automatic rand_txn(input string tag, input bit first);
        logic [DW-1:0] a, b, c, d;
        lfsr_m = lstep(lfsr_m); a = lfsr_m[DW-1:0];
        lfsr_m = lstep(lfsr_m); b = lfsr_m[DW-1:0];
        lfsr_m = lstep(lfsr_m); c = lfsr_m[DW-1:0];
        lfsr_m = lstep(lfsr_m); d = lfsr_m[DW-1:0];
        do_txn(tag, a, b, c, d, 1'b0, first);
    endtask

    task automatic chk_end(input string tag, input int n, input int nerr);
        chk({tag, "_status"}, 64'({busy, done}), 64'b01);
        chk({tag, "_txn_cnt"}, 64'(txn_cnt), 64'(n));
        chk({tag, "_err_cnt"}, 64'(err_cnt), 64'(CHK ? nerr : 0));
        chk({tag, "_err"}, 64'(err), 64'(CHK && nerr != 0));
    endtask

    initial begin
        int w;
        sw_rst = 1'b1; start = 1'b0; mode = 2'd0; txn_num = '0;
        op_ready = 1'b0; res_val = 1'b0; res_re = '0; res_im = '0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        sw_rst = 1'b0;

        // Sweep: operands k..k+3, first op_val GAP+2 edges after start.
        start_run(2'd0, TW'(3));
        for (int k = 0; k < 3; k++)
            do_txn("sweep_ops", DW'(k), DW'(k + 1), DW'(k + 2), DW'(k + 3), 1'b0, k == 0);
        chk_end("sweep", 3, 0);
        repeat (3) @(negedge clk);
        chk("done_held", 64'({busy, done}), 64'b01);

        // Corner: 255 x4, result re=0, im=2*255*255=130050.
        start_run(2'd2, TW'(1));
        wait_op(w);
        chk_ops("corner_ops", 8'd255, 8'd255, 8'd255, 8'd255);
        op_hs();
        res_phase(0, 130050);
        chk_end("corner", 1, 0);

        // Random: bit-exact against the reference LFSR.
        start_run(2'd1, TW'(50));
        for (int k = 0; k < 50; k++) rand_txn("random_ops", k == 0);
        chk_end("random", 50, 0);

        // Alternate: random on k=0 (LFSR continues), corner on k=1.
        start_run(2'd3, TW'(2));
        rand_txn("alt_rand_ops", 1'b0);
        do_txn("alt_corner_ops", 8'd255, 8'd255, 8'd255, 8'd255, 1'b0, 1'b0);
        chk_end("alternate", 2, 0);

        // Backpressure: op_val and operands hold while op_ready is low.
        start_run(2'd0, TW'(1));
        wait_op(w);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold", 64'({op_val, op_1_re, op_1_im, op_2_re, op_2_im}),
                64'({1'b1, 8'd0, 8'd1, 8'd2, 8'd3}));
        end
        op_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_single_hs", 64'(op_val), 64'd0);
        end
        op_ready = 1'b0;
        res_phase(0 * 2 - 1 * 3, 0 * 3 + 1 * 2);
        chk_end("backpressure", 1, 0);

        // Error injection on transaction index 2 of 4.
        start_run(2'd0, TW'(4));
        for (int k = 0; k < 4; k++)
            do_txn("errinj_ops", DW'(k), DW'(k + 1), DW'(k + 2), DW'(k + 3), k == 2, 1'b0);
        chk_end("errinj", 4, 1);

        // Zero-length start from DONE clears counters and flags.
        start_run(2'd0, TW'(0));
        chk_end("zero_from_done", 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("zero_no_op_val", 64'({op_val, done}), 64'b01);
        end

        // sw_rst during WAIT_RES with a result pending.
        start_run(2'd0, TW'(2));
        wait_op(w);
        op_hs();
        res_re = '0; res_im = RW'(2); res_val = 1'b1;
        @(negedge clk);
        sw_rst = 1'b1;
        @(negedge clk);
        sw_rst = 1'b0;
        chk_idle_outputs("midrun_reset");
        res_val = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_after_reset", 64'({op_val, busy, done}), 64'd0);

        // Zero-length start from IDLE.
        start_run(2'd0, TW'(0));
        repeat (2) @(negedge clk);
        chk("zero_from_idle", 64'({op_val, busy, done}), 64'b001);

        // Reset restores the LFSR seed: same first random operands again.
        lfsr_m = SEED;
        start_run(2'd1, TW'(1));
        rand_txn("random_after_reset", 1'b1);
        chk_end("random_after_reset", 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
